// File: rtl/aha_clk_div_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aha_clk_div_sel_ctrl                                                     |
// | Sequences glitch-free switching of the platform clock between the        |
// | source and its /2../32 divided versions (gate closed around mux change). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aha_clk_div_sel_ctrl #(
   parameter int GATE_CYCLES = 4,
   parameter int RESET_DIV   = 0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ,
   input  logic [2:0] REQ_DIV,
   output logic       ACK,
   output logic       ERR,
   output logic       BUSY,
   output logic [2:0] SEL,
   output logic       GATE_EN,
   output logic       DIV_STB
);

   localparam logic [3:0] GATE_LD = 4'(GATE_CYCLES);
   localparam logic [2:0] SEL_RST = 3'(RESET_DIV);
   localparam logic [2:0] MAX_DIV = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DRAIN,
      GATE_PRE,
      SWITCH,
      GATE_POST,
      DONE
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [4:0] phase;
   logic [2:0] nxt;
   logic [2:0] nxt_d;
   logic [3:0] gcnt;
   logic [3:0] gcnt_d;
   logic [2:0] sel_r;
   logic [2:0] sel_d;
   logic       gate_r;
   logic       gate_d;
   logic       busy_r;
   logic       busy_d;
   logic       ack_r;
   logic       ack_d;
   logic       err_r;
   logic       err_d;
   logic       stb_r;
   logic       stb_d;
   logic [2:0] max_k;

   // True when the low k bits of the phase counter are all zero.
   function automatic logic boundary(input logic [2:0] k, input logic [4:0] ph);
      logic [4:0] mask;
      mask = (k > MAX_DIV) ? 5'h1F : 5'((6'd1 << k) - 6'd1);
      return (ph & mask) == 5'd0;
   endfunction

   assign max_k = (sel_r > nxt) ? sel_r : nxt;
   assign stb_d = gate_r & boundary(sel_r, phase);

   always_comb begin
      state_nxt = state;
      nxt_d     = nxt;
      gcnt_d    = gcnt;
      sel_d     = sel_r;
      gate_d    = gate_r;
      busy_d    = busy_r;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      case (state)
         IDLE: begin
            busy_d = REQ;
            if (REQ) begin
               nxt_d     = REQ_DIV;
               state_nxt = CHECK;
            end
         end
         CHECK: begin
            if (nxt > MAX_DIV || nxt == sel_r) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            // Both old and new ratio periods must end on this cycle.
            if (boundary(max_k, phase)) begin
               gate_d    = 1'b0;
               gcnt_d    = GATE_LD;
               state_nxt = (GATE_LD <= 4'd1) ? SWITCH : GATE_PRE;
            end
         end
         GATE_PRE: begin
            gcnt_d = gcnt - 4'd1;
            if (gcnt <= 4'd2) begin
               state_nxt = SWITCH;
            end
         end
         SWITCH: begin
            sel_d     = nxt;
            gcnt_d    = GATE_LD;
            state_nxt = GATE_POST;
         end
         GATE_POST: begin
            gcnt_d = gcnt - 4'd1;
            if (gcnt <= 4'd1) begin
               gate_d    = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            ack_d     = 1'b1;
            err_d     = (nxt > MAX_DIV);
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         phase  <= 5'd0;
         nxt    <= 3'd0;
         gcnt   <= 4'd0;
         sel_r  <= SEL_RST;
         gate_r <= 1'b1;
         busy_r <= 1'b0;
         ack_r  <= 1'b0;
         err_r  <= 1'b0;
         stb_r  <= 1'b0;
      end else begin
         state  <= state_nxt;
         phase  <= phase + 5'd1;
         nxt    <= nxt_d;
         gcnt   <= gcnt_d;
         sel_r  <= sel_d;
         gate_r <= gate_d;
         busy_r <= busy_d;
         ack_r  <= ack_d;
         err_r  <= err_d;
         stb_r  <= stb_d;
      end
   end

   assign ACK     = ack_r;
   assign ERR     = err_r;
   assign BUSY    = busy_r;
   assign SEL     = sel_r;
   assign GATE_EN = gate_r;
   assign DIV_STB = stb_r;

endmodule
`default_nettype wire

// File: tb/tb_aha_clk_div_sel_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aha_clk_div_sel_ctrl                                                  |
// | Randomized bench with a timeline model of the clock switch controller.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_aha_clk_div_sel_ctrl;
   localparam int         G  = 4;
   localparam logic [2:0] RD = 3'd0;

   logic       CLK     = 1'b0;
   logic       RESET   = 1'b1;
   logic       REQ     = 1'b0;
   logic [2:0] REQ_DIV = 3'd0;
   logic       ACK;
   logic       ERR;
   logic       BUSY;
   logic [2:0] SEL;
   logic       GATE_EN;
   logic       DIV_STB;

   int         checks = 0;
   int         errors = 0;
   int         cyc    = 0;
   logic [2:0] m_sel  = RD;

   aha_clk_div_sel_ctrl #(.GATE_CYCLES(G), .RESET_DIV(int'(RD))) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_DIV(REQ_DIV),
      .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .SEL(SEL),
      .GATE_EN(GATE_EN), .DIV_STB(DIV_STB)
   );

   always #5 CLK = ~CLK;

   // Phase seen during a cycle equals edges since reset modulo 32.
   always @(posedge CLK) begin
      if (RESET) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic bit bnd(input int k, input int p);
      return (p % (1 << k)) == 0;
   endfunction

   task automatic idle(input int n);
      bit es;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); @(negedge CLK);
         es = bnd(int'(m_sel), (cyc - 1) % 32);
         checks++;
         if (DIV_STB !== es) begin
            errors++; $display("FAIL idle_div_stb cyc=%0d got=%b exp=%b", cyc, DIV_STB, es);
         end
         checks++;
         if ({ACK, ERR, BUSY, GATE_EN} !== 4'b0001) begin
            errors++; $display("FAIL idle_ctrl cyc=%0d got ack/err/busy/gate=%b exp=0001", cyc, {ACK, ERR, BUSY, GATE_EN});
         end
         checks++;
         if (SEL !== m_sel) begin
            errors++; $display("FAIL idle_sel cyc=%0d got=%0d exp=%0d", cyc, SEL, m_sel);
         end
      end
   endtask

   // One request. j counts edges from acceptance (edge 0). j0=1 means the
   // acceptance edge already happened (REQ held over the previous ACK).
   task automatic run_req(input logic [2:0] d, input bit hold, input logic [2:0] d2,
                          input int j0, output int lat);
      logic [2:0] s, esl, psel;
      int         pa, k, w, jc, jack, pph;
      bit         sw, eg, ea, ee, eb, es, pg;
      s    = m_sel;
      pa   = (j0 == 0) ? cyc % 32 : (cyc - 1) % 32;
      sw   = (d <= 3'd5) && (d != s);
      jc   = -1000;
      jack = 2;
      if (sw) begin
         k = (s > d) ? int'(s) : int'(d);
         w = 0;
         while (((pa + 2 + w) % (1 << k)) != 0) w++;
         jc   = 2 + w;
         jack = 3 + w + 2 * G;
      end
      lat  = -1;
      pg   = 1'b1;
      psel = s;
      pph  = (pa + j0) % 32;
      if (j0 == 0) begin
         REQ = 1'b1; REQ_DIV = d;
      end
      for (int j = j0; j <= jack + 1; j++) begin
         @(posedge CLK); @(negedge CLK);
         eg  = !(sw && j >= jc && j < jc + 2 * G);
         esl = (sw && j >= jc + G) ? d : s;
         ea  = (j == jack);
         ee  = ea && (d > 3'd5);
         eb  = (j <= jack) || (hold && j == jack + 1);
         es  = pg && bnd(int'(psel), pph);
         if (ACK === 1'b1 && lat < 0) lat = j;
         checks++;
         if (GATE_EN !== eg) begin
            errors++; $display("FAIL gate_en req=%0d j=%0d got=%b exp=%b", d, j, GATE_EN, eg);
         end
         checks++;
         if (SEL !== esl) begin
            errors++; $display("FAIL sel req=%0d j=%0d got=%0d exp=%0d", d, j, SEL, esl);
         end
         checks++;
         if (ACK !== ea) begin
            errors++; $display("FAIL ack req=%0d j=%0d got=%b exp=%b", d, j, ACK, ea);
         end
         checks++;
         if (ERR !== ee) begin
            errors++; $display("FAIL err req=%0d j=%0d got=%b exp=%b", d, j, ERR, ee);
         end
         checks++;
         if (BUSY !== eb) begin
            errors++; $display("FAIL busy req=%0d j=%0d got=%b exp=%b", d, j, BUSY, eb);
         end
         checks++;
         if (DIV_STB !== es) begin
            errors++; $display("FAIL div_stb req=%0d j=%0d got=%b exp=%b", d, j, DIV_STB, es);
         end
         pg   = eg;
         psel = esl;
         pph  = (pa + 1 + j) % 32;
         // Drive REQ/REQ_DIV for edge j+1; pulses while busy must be ignored.
         if (j == 0) REQ_DIV = 3'($urandom_range(0, 7));
         if (j + 1 <= jack) begin
            REQ = ($urandom_range(0, 3) == 0);
         end else if (j == jack) begin
            REQ = hold;
            if (hold) REQ_DIV = d2;
         end else begin
            REQ = 1'b0;
         end
      end
      if (sw) m_sel = d;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({ACK, ERR, BUSY, DIV_STB, GATE_EN} !== 5'b00001) begin
         errors++; $display("FAIL reset_ctrl got ack/err/busy/stb/gate=%b exp=00001", {ACK, ERR, BUSY, DIV_STB, GATE_EN});
      end
      checks++;
      if (SEL !== RD) begin
         errors++; $display("FAIL reset_sel got=%0d exp=%0d", SEL, RD);
      end
      RESET = 1'b0;
      m_sel = RD;
      idle(8);
   endtask

   task automatic test_switch_phase5();
      int lat;
      for (int i = 0; i < 40 && (cyc % 32) != 5; i++) idle(1);
      run_req(3'd3, 1'b0, 3'd0, 0, lat);
      idle(40);
   endtask

   task automatic test_error();
      int lat;
      run_req(3'd6, 1'b0, 3'd0, 0, lat);
      idle(2);
      run_req(3'd7, 1'b0, 3'd0, 0, lat);
      idle(1);
   endtask

   task automatic test_same_ratio();
      int lat;
      run_req(m_sel, 1'b0, 3'd0, 0, lat);
      idle(2);
   endtask

   task automatic test_sel5_to_1();
      int lat;
      run_req(3'd5, 1'b0, 3'd0, 0, lat);
      idle(3);
      run_req(3'd1, 1'b0, 3'd0, 0, lat);
      checks++;
      if (lat < 2 || lat > 2 + 31 + 2 * G + 1) begin
         errors++; $display("FAIL latency_5_to_1 got=%0d exp=2..%0d", lat, 2 + 31 + 2 * G + 1);
      end
      idle(4);
   endtask

   task automatic test_random();
      int lat;
      for (int i = 0; i < 25; i++) begin
         run_req(3'($urandom_range(0, 7)), 1'b0, 3'd0, 0, lat);
         idle($urandom_range(0, 4));
      end
   endtask

   task automatic test_reset_mid();
      int         lat, pa, k, w, jc;
      logic [2:0] d;
      run_req(3'd4, 1'b0, 3'd0, 0, lat);
      idle(1);
      d  = 3'd1;
      pa = cyc % 32;
      k  = 4;
      w  = 0;
      while (((pa + 2 + w) % (1 << k)) != 0) w++;
      jc = 2 + w;
      REQ = 1'b1; REQ_DIV = d;
      for (int j = 0; j <= jc + 1; j++) begin
         @(posedge CLK); @(negedge CLK);
         if (j == 0) REQ = 1'b0;
      end
      checks++;
      if (GATE_EN !== 1'b0) begin
         errors++; $display("FAIL gate_closed_before_reset got=%b exp=0", GATE_EN);
      end
      RESET = 1'b1;
      @(posedge CLK); @(negedge CLK);
      checks++;
      if ({ACK, BUSY, GATE_EN} !== 3'b001) begin
         errors++; $display("FAIL reset_mid_ctrl got ack/busy/gate=%b exp=001", {ACK, BUSY, GATE_EN});
      end
      checks++;
      if (SEL !== RD) begin
         errors++; $display("FAIL reset_mid_sel got=%0d exp=%0d", SEL, RD);
      end
      RESET = 1'b0;
      m_sel = RD;
      idle(40);
   endtask

   task automatic test_back_to_back();
      int lat;
      run_req(3'd2, 1'b1, 3'd7, 0, lat);
      run_req(3'd7, 1'b0, 3'd0, 1, lat);
      idle(2);
      run_req(3'd2, 1'b1, 3'd2, 0, lat);
      run_req(3'd2, 1'b0, 3'd0, 1, lat);
      idle(3);
   endtask

   initial begin
      test_reset();
      test_switch_phase5();
      test_error();
      test_same_ratio();
      test_sel5_to_1();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
